// File: rtl/aq_axi_lite_pkg.sv
// aq_axi_lite_pkg: response codes and state encoding shared by the AXI-Lite to AQ_LOCAL bridge
package aq_axi_lite_pkg;
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_W_COLLECT = 3'd1;
  localparam logic [2:0] S_WR_LOCAL  = 3'd2;
  localparam logic [2:0] S_WR_RESP   = 3'd3;
  localparam logic [2:0] S_RD_LOCAL  = 3'd4;
  localparam logic [2:0] S_RD_RESP   = 3'd5;
endpackage

// File: rtl/aq_axi_lite_local_bridge.sv
// aq_axi_lite_local_bridge: single-outstanding AXI4-Lite slave driving the AQ_LOCAL register bus,
// with an ACK timeout that completes a hung access with SLVERR.
module aq_axi_lite_local_bridge
  import aq_axi_lite_pkg::*;
#(
  parameter int TIMEOUT = 255
) (
  input  logic        RST_N,
  input  logic        AQ_LOCAL_CLK,
  input  logic [31:0] S_AXI_AWADDR,
  input  logic        S_AXI_AWVALID,
  output logic        S_AXI_AWREADY,
  input  logic [31:0] S_AXI_WDATA,
  input  logic [3:0]  S_AXI_WSTRB,
  input  logic        S_AXI_WVALID,
  output logic        S_AXI_WREADY,
  output logic [1:0]  S_AXI_BRESP,
  output logic        S_AXI_BVALID,
  input  logic        S_AXI_BREADY,
  input  logic [31:0] S_AXI_ARADDR,
  input  logic        S_AXI_ARVALID,
  output logic        S_AXI_ARREADY,
  output logic [31:0] S_AXI_RDATA,
  output logic [1:0]  S_AXI_RRESP,
  output logic        S_AXI_RVALID,
  input  logic        S_AXI_RREADY,
  output logic        AQ_LOCAL_CS,
  output logic        AQ_LOCAL_RNW,
  input  logic        AQ_LOCAL_ACK,
  output logic [31:0] AQ_LOCAL_ADDR,
  output logic [3:0]  AQ_LOCAL_BE,
  output logic [31:0] AQ_LOCAL_WDATA,
  input  logic [31:0] AQ_LOCAL_RDATA
);
  logic [2:0] state;
  logic prio_rd, aw_got, w_got, awready_q, wready_q, arready_q;
  logic [31:0] awaddr_q, wdata_q, awaddr_n, wdata_n;
  logic [3:0] wstrb_q, wstrb_n;
  logic [15:0] cnt;
  logic idle, wr_req, aw_hs, w_hs, ar_hs, aw_have, w_have, tmo, done;
  // the arbitration loser's READY is masked in the same cycle so only one direction can handshake
  assign idle = state == S_IDLE;
  assign wr_req = S_AXI_AWVALID | S_AXI_WVALID;
  assign S_AXI_AWREADY = awready_q & ~(idle & prio_rd & S_AXI_ARVALID);
  assign S_AXI_WREADY = wready_q & ~(idle & prio_rd & S_AXI_ARVALID);
  assign S_AXI_ARREADY = arready_q & ~(~prio_rd & wr_req);
  assign aw_hs = S_AXI_AWVALID & S_AXI_AWREADY;
  assign w_hs = S_AXI_WVALID & S_AXI_WREADY;
  assign ar_hs = S_AXI_ARVALID & S_AXI_ARREADY;
  assign aw_have = aw_got | aw_hs;
  assign w_have = w_got | w_hs;
  assign awaddr_n = aw_hs ? S_AXI_AWADDR : awaddr_q;
  assign wdata_n = w_hs ? S_AXI_WDATA : wdata_q;
  assign wstrb_n = w_hs ? S_AXI_WSTRB : wstrb_q;
  assign tmo = (TIMEOUT != 0) && (cnt == 16'(TIMEOUT - 1));
  assign done = AQ_LOCAL_ACK | tmo;
  always_ff @(posedge AQ_LOCAL_CLK or negedge RST_N)
    if (!RST_N) begin
      state <= S_IDLE;
      prio_rd <= 1'b0;
      aw_got <= 1'b0;
      w_got <= 1'b0;
      awready_q <= 1'b0;
      wready_q <= 1'b0;
      arready_q <= 1'b0;
      awaddr_q <= '0;
      wdata_q <= '0;
      wstrb_q <= '0;
      cnt <= '0;
      S_AXI_BRESP <= RESP_OKAY;
      S_AXI_BVALID <= 1'b0;
      S_AXI_RDATA <= '0;
      S_AXI_RRESP <= RESP_OKAY;
      S_AXI_RVALID <= 1'b0;
      AQ_LOCAL_CS <= 1'b0;
      AQ_LOCAL_RNW <= 1'b0;
      AQ_LOCAL_ADDR <= '0;
      AQ_LOCAL_BE <= '0;
      AQ_LOCAL_WDATA <= '0;
    end else begin
      case (state)
        S_IDLE, S_W_COLLECT:
          if (ar_hs) begin
            state <= S_RD_LOCAL;
            {awready_q, wready_q, arready_q} <= 3'b000;
            cnt <= '0;
            AQ_LOCAL_CS <= 1'b1;
            AQ_LOCAL_RNW <= 1'b1;
            AQ_LOCAL_ADDR <= S_AXI_ARADDR;
            AQ_LOCAL_BE <= 4'hF;
          end else if (aw_have & w_have) begin
            state <= S_WR_LOCAL;
            {awready_q, wready_q, arready_q} <= 3'b000;
            {aw_got, w_got} <= 2'b00;
            cnt <= '0;
            AQ_LOCAL_CS <= 1'b1;
            AQ_LOCAL_RNW <= 1'b0;
            AQ_LOCAL_ADDR <= awaddr_n;
            AQ_LOCAL_BE <= wstrb_n;
            AQ_LOCAL_WDATA <= wdata_n;
          end else if (aw_hs | w_hs) begin
            state <= S_W_COLLECT;
            {aw_got, w_got} <= {aw_have, w_have};
            {awready_q, wready_q, arready_q} <= {~aw_have, ~w_have, 1'b0};
            awaddr_q <= awaddr_n;
            wdata_q <= wdata_n;
            wstrb_q <= wstrb_n;
          end else if (idle) begin
            {awready_q, wready_q, arready_q} <= 3'b111;
          end
        S_WR_LOCAL, S_RD_LOCAL: begin
          cnt <= cnt + 16'd1;
          if (done) begin
            AQ_LOCAL_CS <= 1'b0;
            state <= (state == S_WR_LOCAL) ? S_WR_RESP : S_RD_RESP;
            if (state == S_WR_LOCAL) begin
              S_AXI_BVALID <= 1'b1;
              S_AXI_BRESP <= AQ_LOCAL_ACK ? RESP_OKAY : RESP_SLVERR;
            end else begin
              S_AXI_RVALID <= 1'b1;
              S_AXI_RRESP <= AQ_LOCAL_ACK ? RESP_OKAY : RESP_SLVERR;
              S_AXI_RDATA <= AQ_LOCAL_ACK ? AQ_LOCAL_RDATA : 32'h0;
            end
          end
        end
        S_WR_RESP:
          if (S_AXI_BREADY) begin
            S_AXI_BVALID <= 1'b0;
            state <= S_IDLE;
            prio_rd <= 1'b1;
            {awready_q, wready_q, arready_q} <= 3'b111;
          end
        S_RD_RESP:
          if (S_AXI_RREADY) begin
            S_AXI_RVALID <= 1'b0;
            state <= S_IDLE;
            prio_rd <= 1'b0;
            {awready_q, wready_q, arready_q} <= 3'b111;
          end
        default: state <= S_IDLE;
      endcase
    end
endmodule
